// File: rtl/add_serial_n_if.sv
// Operand / result bundle for the bit-serial adder. The same bundle fits the
// parallel adder, so either can sit behind one controller or harness.
interface add_serial_n_if #(
  parameter int n = 8
);
  logic         start_i;
  logic [n-1:0] data0_i;
  logic [n-1:0] data1_i;
  logic         busy_o;
  logic         fl_o;
  logic [n:0]   sum_o;

  // requester side: issues operands and start, observes status and result
  modport master (
    output start_i, data0_i, data1_i,
    input  busy_o, fl_o, sum_o
  );

  // adder side
  modport slave (
    input  start_i, data0_i, data1_i,
    output busy_o, fl_o, sum_o
  );
endinterface

// File: rtl/add_serial_n.sv
// Bit-serial unsigned adder: latches two n-bit operands on start, adds them
// LSB-first through one full-adder cell with a registered carry, and
// presents the (n+1)-bit sum with a one-cycle completion flag.
module add_serial_n #(
  parameter int n = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  add_serial_n_if.slave bus
);
  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        state;
  logic [n-1:0]  op_a;
  logic [n-1:0]  op_b;
  logic [n-1:0]  res;
  logic          cy;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          fl;
  logic [n:0]    sum;
  logic          s_bit;
  logic          c_out;

  // One full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // adder cell working on the current operand LSBs and the stored carry
  always_comb begin
    {c_out, s_bit} = full_add(op_a[0], op_b[0], cy);
  end

  // control sequence, serial datapath and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      fl    <= 1'b0;
      sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          fl <= 1'b0;
          if (bus.start_i) begin
            op_a  <= bus.data0_i;
            op_b  <= bus.data1_i;
            cy    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          res  <= {s_bit, res[n-1:1]};
          op_a <= {1'b0, op_a[n-1:1]};
          op_b <= {1'b0, op_b[n-1:1]};
          cy   <= c_out;
          cnt  <= cnt + CW'(1);
          // last bit: the fresh sum bit and carry complete the result
          if (cnt == CW'(n - 1)) begin
            sum   <= {c_out, s_bit, res[n-1:1]};
            busy  <= 1'b0;
            fl    <= 1'b1;
            state <= DONE;
          end else begin
            state <= SHIFT;
          end
        end
        DONE: begin
          fl    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          fl    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = busy;
  assign bus.fl_o   = fl;
  assign bus.sum_o  = sum;
endmodule
